ncap_irq_bridge: RTL and testbench
==================================

// Module: ncap_irq_bridge
// PURPOSE
//  Host-facing end of the NCAP power-state interrupt path. Accepts the 1-cycle
//  interrupt/interrupt_type events from the traffic monitor, holds them pending,
//  and delivers them to the host PCIe IRQ port over a req/ack handshake.
//  Keeps a host-readable W1C cause register, enforces a minimum holdoff between
//  deliveries, and coalesces or supersedes events that arrive faster than the host.
// PARAMETERS
//  CNT_W        16      width of coalesce_count (saturating)
//  ACK_TIMEOUT  1024    cycles to wait for irq_ack (only with NCAP_IRQ_ACK_TIMEOUT_EN)
// PORTS
//  clk             in   1   system clock
//  rst             in   1   synchronous, active-high reset
//  enable          in   1   0: events ignored, no new req (an in-flight req completes)
//  interrupt       in   1   event pulse from monitor
//  interrupt_type  in   1   1=HIGH (go high-perf), 0=LOW (go low-power)
//  holdoff         in   32  min idle cycles after ack before next irq_req
//  irq_req         out  1   interrupt request to host IRQ port
//  irq_vector      out  1   type being delivered; stable while irq_req=1
//  irq_ack         in   1   host port acknowledge, 1-cycle pulse
//  cause           out  2   [1]=HIGH delivered, [0]=LOW delivered; sticky
//  cause_clr       in   2   W1C pulse from host register write
//  coalesce_count  out  CNT_W  events merged or superseded, saturating
//  ack_timeout_err out  1   sticky; cleared only by rst (macro builds only, else tied 0)
// BEHAVIOUR
//  Reset: state=IDLE; irq_req=0, irq_vector=0, cause=0, coalesce_count=0,
//   pend_hi=pend_lo=0, holdoff counter=0, ack_timeout_err=0.
//  Event capture (enable=1, interrupt=1), registered next cycle:
//   - same type already pending          -> no change, coalesce_count+1
//   - opposite type pending, not in flight -> clear it, set new, coalesce_count+1
//   - else                               -> set pend bit for interrupt_type
//   - event of the type in flight (REQ)  -> pends again (re-delivered later)
//  FSM:
//   IDLE: any pend bit -> REQ next cycle; HIGH has priority if both set;
//     irq_vector latched, pend bit of chosen type cleared on entry.
//   REQ: irq_req=1 until irq_ack sampled 1; on ack: irq_req=0 same edge,
//     cause[irq_vector] set, -> HOLD (or IDLE directly if holdoff==0).
//   HOLD: count 1..holdoff; when count==holdoff -> IDLE. holdoff is read on
//     HOLD entry; later changes take effect next HOLD.
//  Latency: pulse at cycle N, IDLE, no holdoff -> irq_req=1 at N+2.
//  irq_ack outside REQ is ignored. ack in same cycle irq_req rises is accepted.
//  cause: cause_clr bit clears; set and clear same cycle -> set wins.
//  coalesce_count saturates at all-ones, never wraps.
//  enable=0: capture disabled, pend bits retained; IDLE does not issue req.
//  rst mid-REQ: irq_req drops next edge; pending events lost.
// CONFIGURATION
//  NCAP_IRQ_ACK_TIMEOUT_EN defined: in REQ, a counter runs; if ACK_TIMEOUT
//   cycles pass with no ack -> irq_req=0, ack_timeout_err=1, cause not set,
//   type re-pended, -> HOLD. Without it: REQ waits forever, ack_timeout_err=0.
// TESTING
//  1 reset, pulse HIGH at c10, ack at c14 -> req c12..c14, vector=1, cause=2'b10.
//  2 holdoff=5, LOW pulse during HIGH REQ -> LOW req rises 6 cycles after HIGH ack.
//  3 three HIGH pulses while HIGH pending -> one delivery, coalesce_count=2.
//  4 LOW pending then HIGH pulse before req -> only HIGH delivered, count=1.
//  5 cause=2'b11, cause_clr=2'b01 while LOW ack -> cause stays 2'b11.
//  6 (macro) ACK_TIMEOUT=8, no ack -> req drops after 8 cycles, err=1, re-req.

Source files
------------

// File: rtl/ncap_irq_bridge.sv
// ncap_irq_bridge: holds NCAP power-state events pending and delivers them to the host IRQ port.
// Optional ack watchdog is built when NCAP_IRQ_ACK_TIMEOUT_EN is defined.
module ncap_irq_bridge #(
    parameter int CNT_W       = 16,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             interrupt,
    input  logic             interrupt_type,
    input  logic [31:0]      holdoff,
    output logic             irq_req,
    output logic             irq_vector,
    input  logic             irq_ack,
    output logic [1:0]       cause,
    input  logic [1:0]       cause_clr,
    output logic [CNT_W-1:0] coalesce_count,
    output logic             ack_timeout_err
);
    // state | meaning
    // IDLE  | waiting for a pending event (and enable) to issue
    // REQ   | irq_req asserted, waiting for irq_ack
    // HOLD  | post-delivery holdoff countdown
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic             pend_hi, pend_lo, pend_hi_nxt, pend_lo_nxt;
    logic [31:0]      hold_cnt, hold_cnt_nxt;
    logic             irq_req_nxt, irq_vector_nxt;
    logic [1:0]       cause_nxt;
    logic [CNT_W-1:0] coal_nxt;
    logic             coal_hit, take_hi, take_lo, leave_req, repend;
    logic             capture;

    if (ACK_TIMEOUT < 1) begin : g_bad_param
        $error("ACK_TIMEOUT must be at least 1");
    end

`ifdef NCAP_IRQ_ACK_TIMEOUT_EN
    localparam int TO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    logic [TO_W-1:0] to_cnt, to_cnt_nxt;
    logic            to_err_nxt;
`endif

    assign capture = enable & interrupt;

    always_comb begin
        state_nxt      = state;
        hold_cnt_nxt   = hold_cnt;
        irq_req_nxt    = irq_req;
        irq_vector_nxt = irq_vector;
        cause_nxt      = cause & ~cause_clr;
        take_hi        = 1'b0;
        take_lo        = 1'b0;
        leave_req      = 1'b0;
        repend         = 1'b0;
        coal_hit       = 1'b0;
`ifdef NCAP_IRQ_ACK_TIMEOUT_EN
        to_cnt_nxt     = to_cnt;
        to_err_nxt     = ack_timeout_err;
`endif
        case (state)
            IDLE: begin
                if (enable && (pend_hi || pend_lo)) begin
                    state_nxt      = REQ;
                    irq_req_nxt    = 1'b1;
                    irq_vector_nxt = pend_hi;
                    take_hi        = pend_hi;
                    take_lo        = ~pend_hi;
`ifdef NCAP_IRQ_ACK_TIMEOUT_EN
                    to_cnt_nxt     = TO_W'(ACK_TIMEOUT - 1);
`endif
                end
            end
            REQ: begin
                if (irq_ack) begin
                    irq_req_nxt = 1'b0;
                    leave_req   = 1'b1;
                    if (irq_vector) cause_nxt[1] = 1'b1;
                    else            cause_nxt[0] = 1'b1;
                end
`ifdef NCAP_IRQ_ACK_TIMEOUT_EN
                else if (to_cnt == '0) begin
                    irq_req_nxt = 1'b0;
                    leave_req   = 1'b1;
                    to_err_nxt  = 1'b1;
                    repend      = 1'b1;
                end else begin
                    to_cnt_nxt = to_cnt - 1'b1;
                end
`endif
            end
            HOLD: begin
                if (hold_cnt == '0) state_nxt = IDLE;
                else                hold_cnt_nxt = hold_cnt - 32'd1;
            end
            default: state_nxt = IDLE;
        endcase

        // The IDLE cycle before the next req is the last holdoff cycle, so HOLD covers holdoff-1.
        if (leave_req) begin
            if (holdoff <= 32'd1) begin
                state_nxt    = IDLE;
                hold_cnt_nxt = '0;
            end else begin
                state_nxt    = HOLD;
                hold_cnt_nxt = holdoff - 32'd2;
            end
        end

        pend_hi_nxt = pend_hi & ~take_hi;
        pend_lo_nxt = pend_lo & ~take_lo;
        if (capture) begin
            if (interrupt_type) begin
                if (pend_hi) begin
                    coal_hit = 1'b1;
                end else begin
                    pend_hi_nxt = 1'b1;
                    if (pend_lo) begin
                        pend_lo_nxt = 1'b0;
                        coal_hit    = 1'b1;
                    end
                end
            end else begin
                if (pend_lo) begin
                    coal_hit = 1'b1;
                end else begin
                    pend_lo_nxt = 1'b1;
                    if (pend_hi) begin
                        pend_hi_nxt = 1'b0;
                        coal_hit    = 1'b1;
                    end
                end
            end
        end
        if (repend) begin
            if (irq_vector) pend_hi_nxt = 1'b1;
            else            pend_lo_nxt = 1'b1;
        end

        coal_nxt = coalesce_count;
        if (coal_hit && (coalesce_count != '1)) coal_nxt = coalesce_count + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            pend_hi        <= 1'b0;
            pend_lo        <= 1'b0;
            hold_cnt       <= '0;
            irq_req        <= 1'b0;
            irq_vector     <= 1'b0;
            cause          <= 2'b00;
            coalesce_count <= '0;
        end else begin
            state          <= state_nxt;
            pend_hi        <= pend_hi_nxt;
            pend_lo        <= pend_lo_nxt;
            hold_cnt       <= hold_cnt_nxt;
            irq_req        <= irq_req_nxt;
            irq_vector     <= irq_vector_nxt;
            cause          <= cause_nxt;
            coalesce_count <= coal_nxt;
        end
    end

`ifdef NCAP_IRQ_ACK_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt          <= '0;
            ack_timeout_err <= 1'b0;
        end else begin
            to_cnt          <= to_cnt_nxt;
            ack_timeout_err <= to_err_nxt;
        end
    end
`else
    assign ack_timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_ncap_irq_bridge.sv
// Directed self-checking bench for ncap_irq_bridge; covers the ack watchdog when
// NCAP_IRQ_ACK_TIMEOUT_EN is defined.
module tb_ncap_irq_bridge;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable;
    logic             interrupt;
    logic             interrupt_type;
    logic [31:0]      holdoff;
    logic             irq_req;
    logic             irq_vector;
    logic             irq_ack;
    logic [1:0]       cause;
    logic [1:0]       cause_clr;
    logic [CNT_W-1:0] coalesce_count;
    logic             ack_timeout_err;

    int passed = 0;
    int total  = 0;
    int exp_coal;
    int n;

    ncap_irq_bridge #(.CNT_W(CNT_W), .ACK_TIMEOUT(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .interrupt      (interrupt),
        .interrupt_type (interrupt_type),
        .holdoff        (holdoff),
        .irq_req        (irq_req),
        .irq_vector     (irq_vector),
        .irq_ack        (irq_ack),
        .cause          (cause),
        .cause_clr      (cause_clr),
        .coalesce_count (coalesce_count),
        .ack_timeout_err(ack_timeout_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic t);
        interrupt      = 1'b1;
        interrupt_type = t;
        step();
        interrupt      = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) begin
            passed = passed + 1;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; enable = 1'b0; interrupt = 1'b0; interrupt_type = 1'b0;
        holdoff = 32'd0; irq_ack = 1'b0; cause_clr = 2'b00;
        step(); step(); step();
        chk("rst_req",   32'(irq_req), 0);
        chk("rst_vec",   32'(irq_vector), 0);
        chk("rst_cause", 32'(cause), 0);
        chk("rst_coal",  32'(coalesce_count), 0);
        chk("rst_err",   32'(ack_timeout_err), 0);
        rst = 1'b0; enable = 1'b1;
        exp_coal = 0;

        // stray ack in IDLE is ignored
        irq_ack = 1'b1; step(); irq_ack = 1'b0; step();
        chk("stray_ack_cause", 32'(cause), 0);
        chk("stray_ack_req",   32'(irq_req), 0);

        // T1: HIGH pulse at N -> req N+2..N+4, ack at N+4
        pulse(1'b1);
        chk("t1_req_n1", 32'(irq_req), 0);
        step();
        chk("t1_req_n2", 32'(irq_req), 1);
        chk("t1_vec",    32'(irq_vector), 1);
        step();
        chk("t1_req_n3", 32'(irq_req), 1);
        step();
        chk("t1_req_n4", 32'(irq_req), 1);
        irq_ack = 1'b1; step(); irq_ack = 1'b0;
        chk("t1_req_drop", 32'(irq_req), 0);
        chk("t1_cause",    32'(cause), 2);
        cause_clr = 2'b10; step(); cause_clr = 2'b00;
        chk("t1_cause_clr", 32'(cause), 0);

        // T2: holdoff=5, LOW pulse during HIGH REQ -> LOW req 6 cycles after ack
        holdoff = 32'd5;
        pulse(1'b1);
        step();
        chk("t2_hi_req", 32'(irq_req), 1);
        pulse(1'b0);
        irq_ack = 1'b1; step(); irq_ack = 1'b0;
        chk("t2_hi_drop",  32'(irq_req), 0);
        chk("t2_cause_hi", 32'(cause), 2);
        step(); step(); step(); step();
        chk("t2_still_low_a5", 32'(irq_req), 0);
        step();
        chk("t2_lo_req_a6", 32'(irq_req), 1);
        chk("t2_lo_vec",    32'(irq_vector), 0);
        irq_ack = 1'b1; step(); irq_ack = 1'b0;
        chk("t2_cause_both", 32'(cause), 3);
        holdoff = 32'd0;
        for (int i = 0; i < 6; i++) step();

        // T3: three HIGH pulses while HIGH pending -> one delivery, coalesce 2
        pulse(1'b1);
        step();
        chk("t3_req", 32'(irq_req), 1);
        pulse(1'b1); step();
        pulse(1'b1); step();
        pulse(1'b1);
        exp_coal = 2;
        chk("t3_coal",     32'(coalesce_count), 32'(exp_coal));
        chk("t3_req_held", 32'(irq_req), 1);
        irq_ack = 1'b1; step(); irq_ack = 1'b0;
        chk("t3_req_gap", 32'(irq_req), 0);
        step();
        chk("t3_redeliver", 32'(irq_req), 1);
        chk("t3_vec",       32'(irq_vector), 1);
        irq_ack = 1'b1; step(); irq_ack = 1'b0;
        step(); step(); step(); step();
        chk("t3_single", 32'(irq_req), 0);

        // T4/T5: holdoff=10; LOW ack with cause_clr=01 keeps 11; LOW then HIGH in HOLD -> HIGH only
        holdoff = 32'd10;
        pulse(1'b0);
        step();
        chk("t4_lo_req", 32'(irq_req), 1);
        irq_ack = 1'b1; cause_clr = 2'b01; step(); irq_ack = 1'b0; cause_clr = 2'b00;
        chk("t5_set_wins", 32'(cause), 3);
        chk("t4_lo_drop",  32'(irq_req), 0);
        pulse(1'b0);
        pulse(1'b1);
        exp_coal = 3;
        chk("t4_coal",    32'(coalesce_count), 32'(exp_coal));
        chk("t4_in_hold", 32'(irq_req), 0);
        n = 0;
        while (irq_req !== 1'b1 && n < 30) begin
            step();
            n++;
        end
        chk("t4_req_delay", 32'(n), 8);
        chk("t4_vec_hi",    32'(irq_vector), 1);
        irq_ack = 1'b1; step(); irq_ack = 1'b0;
        holdoff = 32'd0;
        for (int i = 0; i < 15; i++) step();
        chk("t4_no_low", 32'(irq_req), 0);

        // saturation: 6 more coalesced events on a 3-bit counter stick at 7
        pulse(1'b1);
        step();
        for (int i = 0; i < 7; i++) begin
            pulse(1'b1);
            step();
        end
        exp_coal = (exp_coal + 6 > 7) ? 7 : exp_coal + 6;
        chk("sat_coal", 32'(coalesce_count), 32'(exp_coal));
        irq_ack = 1'b1; step(); irq_ack = 1'b0;
        step();
        chk("sat_redeliver", 32'(irq_req), 1);
        irq_ack = 1'b1; step(); irq_ack = 1'b0;

        // enable=0 holds pending LOW, ignores new HIGH
        pulse(1'b1);
        step();
        pulse(1'b0);
        irq_ack = 1'b1; step(); irq_ack = 1'b0;
        enable = 1'b0;
        pulse(1'b1);
        step(); step(); step();
        chk("en0_no_req", 32'(irq_req), 0);
        enable = 1'b1;
        step();
        chk("en1_req", 32'(irq_req), 1);
        chk("en1_vec", 32'(irq_vector), 0);
        irq_ack = 1'b1; step(); irq_ack = 1'b0;
        chk("en1_drop", 32'(irq_req), 0);

        // reset mid-REQ drops req and loses pending events
        pulse(1'b1);
        step();
        pulse(1'b0);
        rst = 1'b1; step();
        chk("rst_mid_req",   32'(irq_req), 0);
        chk("rst_mid_cause", 32'(cause), 0);
        chk("rst_mid_coal",  32'(coalesce_count), 0);
        rst = 1'b0;
        step(); step(); step();
        chk("rst_pend_lost", 32'(irq_req), 0);

`ifdef NCAP_IRQ_ACK_TIMEOUT_EN
        // T6: no ack -> req high 8 cycles, drops with err, re-requested
        pulse(1'b1);
        step();
        chk("t6_req", 32'(irq_req), 1);
        for (int i = 0; i < 7; i++) step();
        chk("t6_req_last", 32'(irq_req), 1);
        chk("t6_err_pre",  32'(ack_timeout_err), 0);
        step();
        chk("t6_req_drop", 32'(irq_req), 0);
        chk("t6_err",      32'(ack_timeout_err), 1);
        chk("t6_no_cause", 32'(cause), 0);
        step();
        chk("t6_rereq",     32'(irq_req), 1);
        chk("t6_rereq_vec", 32'(irq_vector), 1);
        irq_ack = 1'b1; step(); irq_ack = 1'b0;
        chk("t6_cause",   32'(cause), 2);
        chk("t6_err_sticky", 32'(ack_timeout_err), 1);
`else
        // without the watchdog REQ waits indefinitely
        pulse(1'b1);
        for (int i = 0; i < 20; i++) step();
        chk("nowd_req_held", 32'(irq_req), 1);
        chk("nowd_err",      32'(ack_timeout_err), 0);
        irq_ack = 1'b1; step(); irq_ack = 1'b0;
        chk("nowd_cause", 32'(cause), 2);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
